// File: rtl/otter_mem_pkg.sv
// rtl/otter_mem_pkg.sv - shared types and constants for the OTTER main-memory port arbiter
package otter_mem_pkg;

    localparam int WORDS_PER_LINE = 4;
    localparam int BEAT_W         = $clog2(WORDS_PER_LINE);
    localparam int OFFSET_W       = BEAT_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_FILL = 2'd1,
        ST_D_ACC  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_rr_arb2.sv
// rtl/mem_rr_arb2.sv - two-way round-robin arbiter, I-side wins the first tie
module mem_rr_arb2
    import otter_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       req_i,
    input  logic       req_d,
    output logic [1:0] gnt,
    output grant_t     last_grant
);

    // One-hot grant: bit 0 = I-side, bit 1 = D-side; a tie goes to the side that lost last time
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req_i && req_d) begin
                gnt = (last_grant == GNT_D) ? 2'b01 : 2'b10;
            end else if (req_i) begin
                gnt = 2'b01;
            end else if (req_d) begin
                gnt = 2'b10;
            end
        end
    end

    // Remember the winner of every grant so the next tie flips
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= GNT_D;
        end else if (gnt[0]) begin
            last_grant <= GNT_I;
        end else if (gnt[1]) begin
            last_grant <= GNT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the main-memory port between I-cache line fills and D-side accesses
module mem_port_arbiter
    import otter_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_line_addr,
    output logic              if_word_valid,
    output logic [1:0]        if_word_idx,
    output logic [DATA_W-1:0] if_data,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state, state_next;
    logic [BEAT_W-1:0] beat_cnt, beat_next;
    logic [1:0]        gnt;
    logic              arb_en;
    grant_t            unused_last_grant;
    logic              unused_offset_bits;

    // Line offset bits of the miss address are replaced by the beat counter
    assign unused_offset_bits = ^if_line_addr[OFFSET_W-1:0];

    // Arbitration only happens between transactions, so a fill is never preempted
    assign arb_en = (state == ST_IDLE);

    mem_rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .en         (arb_en),
        .req_i      (if_req),
        .req_d      (d_req),
        .gnt        (gnt),
        .last_grant (unused_last_grant)
    );

    // State and beat counter; async reset abandons any partial transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_next;
        end
    end

    // Next-state and memory/requester outputs; everything idles at zero outside a transaction
    always_comb begin
        state_next    = state;
        beat_next     = beat_cnt;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_be        = 4'h0;
        if_word_valid = 1'b0;
        if_word_idx   = 2'd0;
        if_data       = '0;
        if_done       = 1'b0;
        d_rdata       = '0;
        d_done        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt[0]) begin
                    state_next = ST_I_FILL;
                end else if (gnt[1]) begin
                    state_next = ST_D_ACC;
                end
            end
            ST_I_FILL: begin
                mem_req     = 1'b1;
                mem_be      = 4'hF;
                mem_addr    = {if_line_addr[ADDR_W-1:OFFSET_W], beat_cnt, 2'b00};
                if_word_idx = beat_cnt;
                if_data     = mem_rdata;
                if (mem_ack) begin
                    if_word_valid = 1'b1;
                    beat_next     = beat_cnt + 1'b1;
                    if (beat_cnt == BEAT_W'(WORDS_PER_LINE - 1)) begin
                        if_done    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_D_ACC: begin
                mem_req   = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_be    = d_be;
                d_rdata   = mem_rdata;
                if (mem_ack) begin
                    d_done     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench against a transaction-level model
module tb_mem_port_arbiter;

    localparam int WPL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_line_addr;
    logic        if_word_valid;
    logic [1:0]  if_word_idx;
    logic [31:0] if_data;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .if_req        (if_req),
        .if_line_addr  (if_line_addr),
        .if_word_valid (if_word_valid),
        .if_word_idx   (if_word_idx),
        .if_data       (if_data),
        .if_done       (if_done),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_be          (d_be),
        .d_rdata       (d_rdata),
        .d_done        (d_done),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: who owns the port, which beat of the line, who won last
    int owner;      // 0 = nobody, 1 = I-side fill, 2 = D-side access
    int beat;
    bit last_was_d;
    int fills_done;
    int dacc_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner      = 0;
        beat       = 0;
        last_was_d = 1'b1;
    endtask

    // Check one cycle at the falling edge, advance the model, then release finished requests
    task automatic step();
        bit i_fin;
        bit d_fin;
        @(negedge clk);
        i_fin = 1'b0;
        d_fin = 1'b0;
        chk("mem_req", mem_req, (owner != 0) ? 1 : 0);
        if (owner == 1) begin
            chk("fill_addr", mem_addr, (if_line_addr & 32'hFFFF_FFF0) + 32'(beat * 4));
            chk("fill_we", mem_we, 0);
            chk("fill_be", mem_be, 4'hF);
            chk("fill_valid", if_word_valid, mem_ack);
            chk("fill_done", if_done, (mem_ack && beat == WPL - 1) ? 1 : 0);
            chk("fill_ddone", d_done, 0);
            if (mem_ack) begin
                chk("fill_idx", if_word_idx, beat);
                chk("fill_data", if_data, mem_rdata);
            end
        end else if (owner == 2) begin
            chk("d_addr", mem_addr, d_addr);
            chk("d_we", mem_we, d_we);
            chk("d_wdata", mem_wdata, d_wdata);
            chk("d_be", mem_be, d_be);
            chk("d_done", d_done, mem_ack);
            chk("d_ivalid", if_word_valid, 0);
            chk("d_idone", if_done, 0);
            if (mem_ack && !d_we) chk("d_rdata", d_rdata, mem_rdata);
        end else begin
            chk("idle_valid", if_word_valid, 0);
            chk("idle_idone", if_done, 0);
            chk("idle_ddone", d_done, 0);
        end
        case (owner)
            0: begin
                if (if_req && d_req) owner = last_was_d ? 1 : 2;
                else if (if_req)     owner = 1;
                else if (d_req)      owner = 2;
                if (owner != 0) last_was_d = (owner == 2);
            end
            1: if (mem_ack) begin
                if (beat == WPL - 1) begin
                    owner = 0;
                    beat  = 0;
                    i_fin = 1'b1;
                    fills_done++;
                end else begin
                    beat++;
                end
            end
            default: if (mem_ack) begin
                owner = 0;
                d_fin = 1'b1;
                dacc_done++;
            end
        endcase
        @(posedge clk);
        #1;
        if (i_fin) if_req = 1'b0;
        if (d_fin) d_req = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        if_req       = 1'b0;
        if_line_addr = '0;
        d_req        = 1'b0;
        d_we         = 1'b0;
        d_addr       = '0;
        d_wdata      = '0;
        d_be         = '0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        fills_done   = 0;
        dacc_done    = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_valid", if_word_valid, 0);
        chk("rst_if_idx", if_word_idx, 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_d_done", d_done, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Tie after reset: I fills 0x1230..0x123C first, then the D write
        if_req       = 1'b1;
        if_line_addr = 32'h0000_1234;
        d_req        = 1'b1;
        d_we         = 1'b1;
        d_addr       = 32'h0000_2000;
        d_wdata      = 32'hDEAD_BEEF;
        d_be         = 4'b0011;
        mem_ack      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_rdata = $urandom;
            step();
        end
        chk("tie_i_first", fills_done, 1);
        chk("tie_d_waits", dacc_done, 0);
        for (int i = 0; i < 2; i++) step();
        chk("tie_d_next", dacc_done, 1);

        // D write held off by three wait cycles, then a 20-cycle stall on a read
        d_req  = 1'b1;
        mem_ack = 1'b0;
        step();
        for (int i = 0; i < 3; i++) step();
        mem_ack = 1'b1;
        step();
        chk("dwait_done", dacc_done, 2);
        step();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_4440;
        mem_ack = 1'b0;
        for (int i = 0; i < 21; i++) step();
        chk("stall_no_done", dacc_done, 2);
        mem_ack = 1'b1;
        mem_rdata = 32'h1357_9BDF;
        step();
        step();

        // D request arriving during the second fill beat waits for the line
        if_req       = 1'b1;
        if_line_addr = 32'hABCD_0000;
        step();
        step();
        d_req = 1'b1;
        d_we  = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("mid_fill_done", fills_done, 2);
        chk("mid_d_pending", dacc_done, 3);
        for (int i = 0; i < 3; i++) step();

        // Reset after the second fill ack: port drops at once, no done pulse
        if_req       = 1'b1;
        if_line_addr = 32'h0000_8880;
        for (int i = 0; i < 3; i++) step();
        #1;
        reset = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_if_done", if_done, 0);
        chk("arst_if_valid", if_word_valid, 0);
        if_req = 1'b0;
        d_req  = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        if_req = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Randomized traffic with random memory wait states
        for (int i = 0; i < 3000; i++) begin
            if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req       = 1'b1;
                if_line_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom);
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_be    = 4'($urandom);
            end
            mem_ack   = ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom;
            step();
        end
        chk("rand_progress", (fills_done > 50 && dacc_done > 50) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single main-memory port between the instruction-cache line-fill path and the data-memory path of the pipelined OTTER MCU. I-side requests are 4-word line bursts and D-side requests are single-word reads or writes. A 2-way round-robin picks the winner of each transaction. The block sits between the I-cache/D-side front ends and the main-memory interface, and owns all sequencing of memory beats.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WORDS_PER_LINE, 4, beats per I-cache line fill (power of 2)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  I-cache miss; held until if_done
- if_line_addr  in  ADDR_W  miss address; low log2(WORDS_PER_LINE)+2 bits ignored
- if_word_valid  out  1  beat returned on if_data
- if_word_idx  out  2  word index within line of current beat
- if_data  out  DATA_W  fill data
- if_done  out  1  one-cycle pulse on final fill beat
- d_req  in  1  data access request; held until d_done
- d_we  in  1  1 = write
- d_addr  in  ADDR_W  word address
- d_wdata  in  DATA_W  write data
- d_be  in  4  byte enables
- d_rdata  out  DATA_W  read data
- d_done  out  1  one-cycle pulse, access complete
- mem_req  out  1  beat request to memory
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  beat address
- mem_wdata  out  DATA_W  write data
- mem_be  out  4  byte enables
- mem_ack  in  1  beat accepted/completed; mem_rdata valid this cycle for reads
- mem_rdata  in  DATA_W  read data

## Operation
- States: IDLE, I_FILL, D_ACC.
- In IDLE, only if_req high: go to I_FILL. Only d_req high: go to D_ACC.
- In IDLE, both high: grant the side that did not win the previous grant; last_grant is updated on every grant. Reset value of last_grant = D, so I wins the first tie.
- I_FILL:
  - mem_req=1, mem_we=0, mem_be=4'hF.
  - mem_addr = {line tag, beat_cnt, 2'b00}.
  - On mem_ack: if_word_valid=1, if_word_idx=beat_cnt, if_data=mem_rdata, then beat_cnt++.
  - On ack with beat_cnt==WORDS_PER_LINE-1: if_done=1, beat_cnt wraps to 0, go to IDLE.
  - A fill is never preempted by d_req.
- D_ACC:
  - mem_req=1; mem_we, mem_addr, mem_wdata and mem_be are driven from the d_* inputs.
  - On mem_ack: d_done=1, d_rdata=mem_rdata (value is don't-care for writes), go to IDLE.
- mem_req is held with a stable address, data and enables until mem_ack. With no ack, the block waits indefinitely.
- if_word_valid, if_done and d_done are combinational from mem_ack and state. if_data and d_rdata pass mem_rdata through.
- Reset values: state IDLE, beat_cnt 0, last_grant D. All outputs are 0.
- Reset mid-transaction: mem_req drops immediately and the partial fill is abandoned with no done pulse. The requester re-issues after reset.
- A req still high in IDLE after its done pulse is treated as a new request. Requesters must drop req in the cycle after done.

## Timing
- A req sampled in IDLE at edge N raises mem_req after edge N. The first beat can therefore be acked in cycle N+1.
- Minimum one IDLE cycle between transactions, so there is no back-to-back grant.
- With a zero-wait memory (mem_ack tied high during mem_req), a fill takes 4 active cycles plus 1 IDLE, and a D access takes 1 plus 1.
- A request arriving while the other side is mid-transaction waits for return to IDLE and then wins by round-robin or by being the sole requester.

## Structure
- Shared package otter_mem_pkg holds:
  - the state enum
  - WORDS_PER_LINE
  - OFFSET_W = log2(WORDS_PER_LINE)+2
  - grant encoding (GNT_I, GNT_D)
- One natural sub-module: mem_rr_arb2. It takes two requests and an enable, and outputs a one-hot grant and the last_grant register. It is instantiated once.

## Test plan
- if_req=1, if_line_addr=0x0000_1234, mem_ack always high:
  - mem_addr sequence is 0x1230, 0x1234, 0x1238, 0x123C.
  - if_word_idx is 0..3, with if_done on the 4th beat.
- d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011, ack after 3 wait cycles:
  - mem_* outputs are stable for 4 cycles.
  - d_done pulses once, in the ack cycle.
- if_req and d_req rise together after reset: I granted first (full 4-beat fill), D granted next. Repeated ties alternate D, I, D.
- d_req rises during the 2nd fill beat:
  - The fill completes uninterrupted.
  - D_ACC starts after one IDLE cycle.
- reset asserted low after the 2nd fill ack:
  - mem_req=0 asynchronously, with no if_done.
  - After release, a re-issued if_req restarts at beat 0.
- d_req with mem_ack low for 20 cycles: mem_req stays high with mem_addr unchanged, and d_done=0 throughout.
